// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART TX serializer on the baud clock; parity built only with UART_TX_PARITY_EN
// Frames: start, DATA_W bits LSB-first, optional parity, STOP_BITS stops; back-to-back on valid/ready.
module uart_tx_frame #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              iTX_BAUD_clk,
    input  logic              reset,
    input  logic              iTX_VALID,
    input  logic [DATA_W-1:0] iTX_DATA,
    output logic              oTX_READY,
    output logic              oTX_DATA,
    output logic              oTX_BUSY,
    output logic              oTX_DONE
);
    localparam int CNT_W = $clog2(DATA_W);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               line_q, line_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic last_data;
    logic last_stop;
    logic accept;

    // The state names what is on the line right now, so readiness follows the last stop period.
    assign last_data = (cnt_q == CNT_W'(DATA_W - 1));
    assign last_stop = (state_q == S_STOP) && (cnt_q == CNT_W'(STOP_BITS - 1));
    assign oTX_READY = (state_q == S_IDLE) || last_stop;
    assign accept    = iTX_VALID && oTX_READY;

    assign oTX_DATA = line_q;
    assign oTX_BUSY = busy_q;
    assign oTX_DONE = done_q;

    always_ff @(posedge iTX_BAUD_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            line_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            line_q   <= line_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        line_d   = line_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                busy_d = 1'b0;
            end
            S_START: begin
                line_d  = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (last_data) begin
`ifdef UART_TX_PARITY_EN
                    line_d  = parity_q;
                    state_d = S_PARITY;
`else
                    line_d  = 1'b1;
                    cnt_d   = '0;
                    done_d  = (STOP_BITS == 1);
                    state_d = S_STOP;
`endif
                end else begin
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                line_d  = 1'b1;
                cnt_d   = '0;
                done_d  = (STOP_BITS == 1);
                state_d = S_STOP;
            end
`endif
            S_STOP: begin
                line_d = 1'b1;
                if (last_stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    done_d = ((cnt_q + CNT_W'(1)) == CNT_W'(STOP_BITS - 1));
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Acceptance overrides the end-of-frame path so the next start bit follows with no gap.
        if (accept) begin
            state_d  = S_START;
            shift_d  = iTX_DATA;
            cnt_d    = '0;
            line_d   = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = (^iTX_DATA) ^ 1'(PARITY_ODD);
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - bench for uart_tx_frame: two configurations checked every cycle against a frame model
module tb_uart_tx_frame;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic [1:0] ready_w, line_w, busy_w, done_w;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_frame #(.DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .iTX_BAUD_clk(clk), .reset(rst_n), .iTX_VALID(valid), .iTX_DATA(data),
        .oTX_READY(ready_w[0]), .oTX_DATA(line_w[0]), .oTX_BUSY(busy_w[0]), .oTX_DONE(done_w[0])
    );
    uart_tx_frame #(.DATA_W(7), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .iTX_BAUD_clk(clk), .reset(rst_n), .iTX_VALID(valid), .iTX_DATA(data[6:0]),
        .oTX_READY(ready_w[1]), .oTX_DATA(line_w[1]), .oTX_BUSY(busy_w[1]), .oTX_DONE(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", nm, k, $time, got, exp);
        end
    endtask

    // Frame as a bit vector: bit p is the line level during period p of the frame.
    function automatic logic [15:0] build(input logic [8:0] d, input int w, input int s,
                                          input bit pe, input bit odd, output int len);
        logic [15:0] f;
        logic        p;
        f = '1;
        f[0] = 1'b0;
        p = odd;
        for (int i = 0; i < w; i++) begin
            f[1 + i] = d[i];
            p = p ^ d[i];
        end
        if (pe) f[1 + w] = p;
        len = 1 + w + int'(pe) + s;
        build = f & ((16'(1) << len) - 16'(1));
    endfunction

    int          cfg_w[2]  = '{8, 7};
    int          cfg_s[2]  = '{1, 2};
    bit          cfg_o[2]  = '{1'b0, 1'b1};
    bit          m_idle[2] = '{1'b1, 1'b1};
    int          m_pos[2]  = '{0, 0};
    int          m_len[2]  = '{10, 10};
    int          acc_cnt[2] = '{0, 0};
    logic [15:0] m_frame[2] = '{16'h0, 16'h0};

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                logic [8:0] d;
                bit         rdy;
                int         ln;
                d = (k == 0) ? {1'b0, data} : {2'b00, data[6:0]};
                rdy = m_idle[k] || (m_pos[k] == m_len[k] - 1);
                if (!rst_n) begin
                    m_idle[k] = 1'b1;
                end else if (valid && rdy) begin
                    m_frame[k] = build(d, cfg_w[k], cfg_s[k], PAR_EN, cfg_o[k], ln);
                    m_len[k]   = ln;
                    m_pos[k]   = 0;
                    m_idle[k]  = 1'b0;
                    acc_cnt[k]++;
                end else if (!m_idle[k]) begin
                    if (m_pos[k] == m_len[k] - 1) m_idle[k] = 1'b1;
                    else m_pos[k]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic e_line, e_busy, e_done, e_rdy;
                if (!rst_n || m_idle[k]) begin
                    e_line = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
                end else begin
                    e_line = m_frame[k][m_pos[k]];
                    e_busy = 1'b1;
                    e_done = (m_pos[k] == m_len[k] - 1);
                    e_rdy  = e_done;
                end
                chk("line",  k, 16'(line_w[k]),  16'(e_line));
                chk("busy",  k, 16'(busy_w[k]),  16'(e_busy));
                chk("done",  k, 16'(done_w[k]),  16'(e_done));
                chk("ready", k, 16'(ready_w[k]), 16'(e_rdy));
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        #1 valid = 1'b1; data = d;
        @(negedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_w == 2'b00) break;
        end
        chk(nm, 0, 16'(busy_w), 16'h0);
    endtask

    initial begin
        int ln;
        int a0, a1;
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;

        chk("pin_a5",     0, build(9'h0A5, 8, 1, 1'b0, 1'b0, ln), 16'h034A);
        chk("pin_a5_len", 0, 16'(ln), 16'd10);
        chk("pin_55_w7s2", 1, build(9'h055, 7, 2, 1'b0, 1'b0, ln), 16'h03AA);
        chk("pin_55_len", 1, 16'(ln), 16'd10);
        chk("pin_07_even", 0, build(9'h007, 8, 1, 1'b1, 1'b0, ln), 16'h060E);
        chk("pin_07_odd",  0, build(9'h007, 8, 1, 1'b1, 1'b1, ln), 16'h040E);
        chk("pin_07_len",  0, 16'(ln), 16'd11);
        chk("pin_00", 0, build(9'h000, 8, 1, 1'b0, 1'b0, ln), 16'h0200);
        chk("pin_ff", 0, build(9'h0FF, 8, 1, 1'b0, 1'b0, ln), 16'h03FE);

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        repeat (20) @(negedge clk);
        chk("idle_line",  0, 16'(line_w),  16'h3);
        chk("idle_ready", 0, 16'(ready_w), 16'h3);
        chk("idle_busy",  0, 16'(busy_w),  16'h0);

        send(8'hA5);
        wait_idle("a5_timeout");

        @(negedge clk);
        #1 valid = 1'b1; data = 8'h00;
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        @(negedge clk);
        #1 data = 8'hFF;
        for (int c = 0; c < 60; c++) begin
            if (acc_cnt[0] >= a0 + 2 && acc_cnt[1] >= a1 + 2) break;
            @(negedge clk);
        end
        chk("b2b_accepts", 0, 16'(acc_cnt[0] - a0), 16'd2);
        #1 valid = 1'b0;
        wait_idle("b2b_timeout");

        send(8'h07);
        wait_idle("p07_timeout");
        send(8'h55);
        wait_idle("p55_timeout");

        send(8'h3C);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_line", 0, 16'(line_w), 16'h3);
        chk("rst_busy", 0, 16'(busy_w), 16'h0);
        chk("rst_done", 0, 16'(done_w), 16'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        send(8'hC3);
        wait_idle("c3_timeout");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
